// File: rtl/clktick_pkg.sv
// clktick_pkg: shared modes, channel states and default widths for the clktick_multi tick generator
package clktick_pkg;
  typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} clktick_mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PERIODIC, ST_ONESHOT} clktick_state_t;
  localparam int CLKTICK_N_BIT = 16;
  localparam int CLKTICK_N_CH = 4;
endpackage

// File: rtl/clktick_chan.sv
// clktick_chan: one tick channel; clkin/rst, en freezes, sync restarts, wr_sel loads wr_k/wr_mode, tick registered strobe, busy = armed
module clktick_chan import clktick_pkg::*; #(
  parameter int N_BIT = CLKTICK_N_BIT
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_sel,
  input  logic [N_BIT-1:0] wr_k,
  input  clktick_mode_t    wr_mode,
  output logic             tick,
  output logic             busy
);
  clktick_state_t state, state_n;
  logic [N_BIT-1:0] k_reg, k_n, count, count_n;
  logic tick_n;
  always_comb begin
    state_n = state;
    k_n = k_reg;
    count_n = count;
    tick_n = 1'b0;
    if (wr_sel) begin
      k_n = wr_k;
      count_n = wr_k - N_BIT'(1);
      state_n = (wr_k == '0) ? ST_IDLE : (wr_mode == MODE_ONESHOT) ? ST_ONESHOT : ST_PERIODIC;
    end else if (state != ST_IDLE) begin
      if (sync) count_n = k_reg - N_BIT'(1);
      else if (en) begin
        if (count != '0) count_n = count - N_BIT'(1);
        else begin
          tick_n = 1'b1;
          count_n = (state == ST_PERIODIC) ? k_reg - N_BIT'(1) : count;
          state_n = (state == ST_ONESHOT) ? ST_IDLE : state;
        end
      end
    end
  end
  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= ST_IDLE;
      k_reg <= '0;
      count <= '0;
      tick <= 1'b0;
    end else begin
      state <= state_n;
      k_reg <= k_n;
      count <= count_n;
      tick <= tick_n;
    end
  end
  assign busy = (state != ST_IDLE);
endmodule

// File: rtl/clktick_multi.sv
// clktick_multi: N_CH tick generator; clkin/rst, en global freeze, wr/wr_ch/wr_k/wr_mode program one channel, sync realigns all, tick/busy per channel
module clktick_multi import clktick_pkg::*; #(
  parameter int N_BIT = CLKTICK_N_BIT,
  parameter int N_CH = CLKTICK_N_CH,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [N_BIT-1:0] wr_k,
  input  logic             wr_mode,
  input  logic             sync,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  busy
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clktick_chan #(.N_BIT(N_BIT)) u_chan (
      .clkin(clkin),
      .rst(rst),
      .en(en),
      .sync(sync),
      .wr_sel(wr && (32'(wr_ch) == i)),
      .wr_k(wr_k),
      .wr_mode(clktick_mode_t'(wr_mode)),
      .tick(tick[i]),
      .busy(busy[i])
    );
  end
endmodule

// File: tb/tb_clktick_multi.sv
// tb_clktick_multi: table vectors, directed corner sequences and random stimulus against a cycles-remaining model
module tb_clktick_multi;
  localparam int N_CH = 5;
  localparam int CH_W = 3;
  logic clkin = 1'b0, rst = 1'b0, en = 1'b0, wr = 1'b0, wr_mode = 1'b0, sync = 1'b0;
  logic [CH_W-1:0] wr_ch = '0;
  logic [15:0] wr_k = '0;
  logic [N_CH-1:0] tick, busy;
  int vectors = 0, miscompares = 0;
  int m_rem[N_CH], m_k[N_CH];
  logic [N_CH-1:0] m_arm = '0, m_one = '0, m_tick = '0;
  typedef struct packed {
    logic r, e, w;
    logic [2:0] ch;
    logic [15:0] k;
    logic md, s;
    logic [4:0] et, eb;
  } vec_t;
  vec_t tbl[$];

  clktick_multi #(.N_BIT(16), .N_CH(N_CH), .CH_W(CH_W)) dut (
    .clkin(clkin), .rst(rst), .en(en), .wr(wr), .wr_ch(wr_ch), .wr_k(wr_k),
    .wr_mode(wr_mode), .sync(sync), .tick(tick), .busy(busy)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string nm, input logic [N_CH-1:0] a, input logic [N_CH-1:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic check1(input string nm, input logic a, input logic e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model(input logic r, e, w, input logic [2:0] ch, input int k, input logic md, s);
    for (int c = 0; c < N_CH; c++) begin
      m_tick[c] = 1'b0;
      if (r) begin
        m_arm[c] = 1'b0;
        m_rem[c] = 0;
        m_k[c] = 0;
      end else if (w && ch == c) begin
        m_k[c] = k;
        m_rem[c] = k;
        m_one[c] = md;
        m_arm[c] = (k != 0);
      end else if (m_arm[c]) begin
        if (s) m_rem[c] = m_k[c];
        else if (e) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_tick[c] = 1'b1;
            m_rem[c] = m_k[c];
            if (m_one[c]) m_arm[c] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, e, w, input logic [2:0] ch, input logic [15:0] k, input logic md, s);
    @(negedge clkin);
    rst = r; en = e; wr = w; wr_ch = ch; wr_k = k; wr_mode = md; sync = s;
    model(r, e, w, ch, int'(k), md, s);
    @(posedge clkin);
    #1;
    check("model_tick", tick, m_tick);
    check("model_busy", busy, m_arm);
  endtask

  task automatic idle(input logic e);
    step(1'b0, e, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic wrch(input logic [2:0] ch, input logic [15:0] k, input logic md);
    step(1'b0, 1'b1, 1'b1, ch, k, md, 1'b0);
  endtask

  initial begin
    tbl.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00000});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 3'd0, 16'd5, 1'b0, 1'b0, 5'b00000, 5'b00001});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00001, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 3'd1, 16'd3, 1'b1, 1'b0, 5'b00000, 5'b00011});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00011});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00011});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00010, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00001, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 3'd5, 16'd7, 1'b0, 1'b0, 5'b00000, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 3'd7, 16'd2, 1'b1, 1'b0, 5'b00000, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00001});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00001, 5'b00001});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 5'b00000, 5'b00000});
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].ch, tbl[i].k, tbl[i].md, tbl[i].s);
      check($sformatf("tbl%0d_tick", i), tick, tbl[i].et);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
    end

    wrch(3'd0, 16'd4, 1'b0);
    idle(1'b1);
    idle(1'b1);
    for (int j = 0; j < 3; j++) begin
      idle(1'b0);
      check1("en_low_tick", tick[0], 1'b0);
    end
    idle(1'b1);
    check1("en_stretch_early", tick[0], 1'b0);
    idle(1'b1);
    check1("en_stretch_tick", tick[0], 1'b1);

    step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    wrch(3'd0, 16'd4, 1'b0);
    wrch(3'd2, 16'd6, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1);
    check("sync_expiry_tick", tick, 5'b00000);
    for (int j = 1; j <= 12; j++) begin
      idle(1'b1);
      check1($sformatf("sync_ch0_%0d", j), tick[0], (j % 4) == 0);
      check1($sformatf("sync_ch2_%0d", j), tick[2], (j % 6) == 0);
    end

    step(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    wrch(3'd3, 16'd2, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check1("k2_tick", tick[3], 1'b1);
    idle(1'b1);
    wrch(3'd3, 16'd4, 1'b0);
    check1("wr_on_expiry", tick[3], 1'b0);
    for (int j = 0; j < 3; j++) idle(1'b1);
    check1("rewrite_early", tick[3], 1'b0);
    idle(1'b1);
    check1("rewrite_tick", tick[3], 1'b1);
    wrch(3'd3, 16'd0, 1'b0);
    check1("k0_busy", busy[3], 1'b0);
    for (int j = 0; j < 6; j++) begin
      idle(1'b1);
      check1("k0_tick", tick[3], 1'b0);
    end

    wrch(3'd4, 16'd1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      idle(1'b1);
      check1("k1_tick", tick[4], 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    check("rst_tick", tick, 5'b00000);
    check("rst_busy", busy, 5'b00000);
    for (int j = 0; j < 3; j++) idle(1'b1);
    check("post_rst_busy", busy, 5'b00000);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom_range(3, 12)),
           1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
